instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/program_counter.sv | 27 ++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, the HLT opcode and the fetch state encoding for the CPU front end.
package cpu_pkg;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 5;
  localparam int OPERAND_W = DATA_W - OPCODE_W;

  localparam logic [OPCODE_W-1:0] OP_HLT = 5'b00000;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_hlt(input logic [DATA_W-1:0] word);
    return word[DATA_W-1:DATA_W-OPCODE_W] == OP_HLT;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: a jump load beats an increment; it holds otherwise and wraps at the top of the space.
module program_counter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one-cycle capture of the program word into a valid/ready output register.
// A jump flushes the register, and HLT freezes fetch until reset.
module instruction_fetch
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    Prog_Addr,
  input  logic [DATA_W-1:0]    Prog_Data,
  input  logic                 Jump_En,
  input  logic [ADDR_W-1:0]    Jump_Addr,
  output logic [DATA_W-1:0]    Instr,
  output logic [OPCODE_W-1:0]  Opcode,
  output logic [OPERAND_W-1:0] Operand,
  output logic                 Instr_Valid,
  input  logic                 Instr_Ready,
  output logic                 Halted,
  output logic [15:0]          Fetch_Count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic [15:0]       r_count;

  logic              w_capture;
  logic              w_jump;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A jump outranks capture; HALTED ignores both, so only reset leaves it.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_jump      = 1'b0;
    w_pc_inc    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (Jump_En) begin
          w_jump = 1'b1;
        end else if (!r_valid || Instr_Ready) begin
          w_capture = 1'b1;
          if (is_hlt(Prog_Data)) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  program_counter u_pc (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_jump),
    .i_load_addr (Jump_Addr),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else if (w_jump) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr <= Prog_Data;
      r_valid <= 1'b1;
      r_count <= r_count + 16'd1;
    end else if (Instr_Ready) begin
      r_valid <= 1'b0;
    end
  end

  assign Prog_Addr   = w_pc;
  assign Instr       = r_instr;
  assign Opcode      = r_instr[DATA_W-1:OPERAND_W];
  assign Operand     = r_instr[OPERAND_W-1:0];
  assign Instr_Valid = r_valid;
  assign Halted      = (r_state == ST_HALTED);
  assign Fetch_Count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a behavioural program-memory fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [10:0] Prog_Addr;
  logic [15:0] Prog_Data;
  logic        Jump_En;
  logic [10:0] Jump_Addr;
  logic [15:0] Instr;
  logic [4:0]  Opcode;
  logic [10:0] Operand;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic        Halted;
  logic [15:0] Fetch_Count;

  logic [15:0] mem [0:2047];

  int n_total = 0;
  int n_pass  = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .Prog_Addr   (Prog_Addr),
    .Prog_Data   (Prog_Data),
    .Jump_En     (Jump_En),
    .Jump_Addr   (Jump_Addr),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .Operand     (Operand),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .Halted      (Halted),
    .Fetch_Count (Fetch_Count)
  );

  assign Prog_Data = mem[Prog_Addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model: the fetch stage as an address walker over the memory array.
  bit          m_live = 0;
  int          m_pc;
  logic [15:0] m_instr;
  bit          m_vld;
  bit          m_halt;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_live  = 1;
      m_pc    = 0;
      m_instr = 16'h0000;
      m_vld   = 0;
      m_halt  = 0;
      m_cnt   = 0;
    end else if (m_live) begin
      if (m_halt) begin
        if (m_vld && Instr_Ready) m_vld = 0;
      end else if (Jump_En) begin
        m_pc  = int'(Jump_Addr);
        m_vld = 0;
      end else if (!m_vld || Instr_Ready) begin
        m_instr = mem[m_pc];
        m_vld   = 1;
        m_cnt   = (m_cnt + 1) % 65536;
        if (m_instr[15:11] == 5'd0) m_halt = 1;
        else                        m_pc = (m_pc + 1) % 2048;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("Prog_Addr",   32'(Prog_Addr),   32'(m_pc));
      check("Instr",       32'(Instr),       32'(m_instr));
      check("Opcode",      32'(Opcode),      32'(m_instr[15:11]));
      check("Operand",     32'(Operand),     32'(m_instr[10:0]));
      check("Instr_Valid", 32'(Instr_Valid), 32'(m_vld));
      check("Halted",      32'(Halted),      32'(m_halt));
      check("Fetch_Count", 32'(Fetch_Count), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  32'(Prog_Addr),   32'h0);
    check({tag, "_instr"}, 32'(Instr),       32'h0);
    check({tag, "_vld"},   32'(Instr_Valid), 32'h0);
    check({tag, "_halt"},  32'(Halted),      32'h0);
    check({tag, "_cnt"},   32'(Fetch_Count), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {5'd1, 11'(i)};
    mem[0] = 16'h6000;
    mem[1] = 16'h6301;
    mem[2] = 16'h6C02;
    mem[5] = 16'h0000;

    reset = 1'b1; Jump_En = 1'b0; Jump_Addr = '0; Instr_Ready = 1'b0;
    tick(); tick();
    check_reset_vals("rst0");

    // Straight-line fetch with decode always ready.
    reset = 1'b0; Instr_Ready = 1'b1;
    tick(); check("A_i0", 32'(Instr), 32'h6000); check("A_v0", 32'(Instr_Valid), 32'h1);
    tick(); check("A_i1", 32'(Instr), 32'h6301);
    tick(); check("A_i2", 32'(Instr), 32'h6C02); check("A_cnt", 32'(Fetch_Count), 32'd3);
    check("A_opc", 32'(Opcode), 32'h0D); check("A_opr", 32'(Operand), 32'h402);

    // Stall for four cycles right after the first capture.
    reset = 1'b1; tick();
    reset = 1'b0; Instr_Ready = 1'b0;
    tick(); check("B_i0", 32'(Instr), 32'h6000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("B_hold_i", 32'(Instr), 32'h6000);
      check("B_hold_a", 32'(Prog_Addr), 32'd1);
      check("B_hold_c", 32'(Fetch_Count), 32'd1);
    end
    Instr_Ready = 1'b1;
    tick(); check("B_resume", 32'(Instr), 32'h6301);

    // Jump with a valid word being accepted in the same cycle.
    Jump_En = 1'b1; Jump_Addr = 11'd100;
    tick(); check("C_vld", 32'(Instr_Valid), 32'h0); check("C_addr", 32'(Prog_Addr), 32'd100);
    Jump_En = 1'b0;
    tick(); check("C_instr", 32'(Instr), 32'h0864); check("C_addr2", 32'(Prog_Addr), 32'd101);

    // Jump to the last address, capture there, and wrap.
    Jump_En = 1'b1; Jump_Addr = 11'd2047;
    tick(); check("D_addr", 32'(Prog_Addr), 32'd2047);
    Jump_En = 1'b0;
    tick(); check("D_instr", 32'(Instr), 32'h0FFF); check("D_wrap", 32'(Prog_Addr), 32'd0);

    // Run 0..5; the HLT at 5 stops fetch.
    for (int k = 0; k < 6; k++) tick();
    check("E_halt", 32'(Halted), 32'h1); check("E_addr", 32'(Prog_Addr), 32'd5);
    check("E_instr", 32'(Instr), 32'h0000); check("E_cnt", 32'(Fetch_Count), 32'd10);
    Instr_Ready = 1'b0; Jump_En = 1'b1; Jump_Addr = 11'd77;
    tick(); tick();
    check("E_vld_held", 32'(Instr_Valid), 32'h1); check("E_jmp_ign", 32'(Prog_Addr), 32'd5);
    Instr_Ready = 1'b1;
    tick(); check("E_vld_clr", 32'(Instr_Valid), 32'h0);
    check("E_cnt_frz", 32'(Fetch_Count), 32'd10); check("E_halt2", 32'(Halted), 32'h1);

    // Halt again, then reset while halted, stalled and jumping.
    Jump_En = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; Instr_Ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("F_halt", 32'(Halted), 32'h1);
    Instr_Ready = 1'b0; Jump_En = 1'b1; Jump_Addr = 11'd300;
    tick();
    reset = 1'b1;
    tick(); check_reset_vals("rst1");
    reset = 1'b0; Jump_En = 1'b0; Instr_Ready = 1'b1;
    tick(); check("F_restart", 32'(Instr), 32'h6000); check("F_addr", 32'(Prog_Addr), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
